// File: rtl/alu_exec_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : alu_exec_ctrl
// Function : Command sequencer for the 16-bit ALU with an 8x16 register file,
//            a flags register and valid/ready command/response handshakes.
// Revision : 1.0
// ============================================================================
module alu_exec_ctrl (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [4:0]  cmd_op,
    input  logic [2:0]  cmd_rd,
    input  logic [2:0]  cmd_rs1,
    input  logic [2:0]  cmd_rs2,
    input  logic        cmd_imm_en,
    input  logic [15:0] cmd_imm,
    output logic [15:0] alu_a,
    output logic [15:0] alu_b,
    output logic [4:0]  alu_f,
    output logic        alu_cin,
    input  logic [15:0] alu_result,
    input  logic [5:0]  alu_status,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [15:0] rsp_data,
    output logic [5:0]  rsp_flags,
    output logic        rsp_err,
    output logic [5:0]  flags_q,
    input  logic [2:0]  dbg_addr,
    output logic [15:0] dbg_data
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] rf_q [8];
    logic [15:0] alu_a_q, alu_b_q;
    logic [4:0]  alu_f_q;
    logic [2:0]  rd_q;
    logic        illegal_q;
    logic [15:0] rsp_data_q;
    logic [5:0]  rsp_flags_q;
    logic        rsp_err_q;
    logic [5:0]  flags_reg_q;
    logic        w_accept;
    logic        w_legal;

    assign w_accept = cmd_valid && (state_q == S_IDLE);

    // Legal set: 0x01, 0x03-0x0B, 0x10-0x17
    always_comb begin
        w_legal = 1'b0;
        if (cmd_op == 5'h01)
            w_legal = 1'b1;
        else if ((cmd_op >= 5'h03) && (cmd_op <= 5'h0B))
            w_legal = 1'b1;
        else if ((cmd_op >= 5'h10) && (cmd_op <= 5'h17))
            w_legal = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state_q <= S_IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (cmd_valid) state_d = S_EXEC;
            S_EXEC:  state_d = S_RESP;
            S_RESP:  if (rsp_ready) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 8; i++) rf_q[i] <= '0;
            alu_a_q     <= '0;
            alu_b_q     <= '0;
            alu_f_q     <= '0;
            rd_q        <= '0;
            illegal_q   <= 1'b0;
            rsp_data_q  <= '0;
            rsp_flags_q <= '0;
            rsp_err_q   <= 1'b0;
            flags_reg_q <= '0;
        end else begin
            if (w_accept) begin
                alu_a_q   <= rf_q[cmd_rs1];
                alu_b_q   <= cmd_imm_en ? cmd_imm : rf_q[cmd_rs2];
                alu_f_q   <= cmd_op;
                rd_q      <= cmd_rd;
                illegal_q <= !w_legal;
            end
            // Illegal commands report the unchanged flags and never write back
            if (state_q == S_EXEC) begin
                if (illegal_q) begin
                    rsp_data_q  <= '0;
                    rsp_flags_q <= flags_reg_q;
                    rsp_err_q   <= 1'b1;
                end else begin
                    rsp_data_q  <= alu_result;
                    rsp_flags_q <= alu_status;
                    rsp_err_q   <= 1'b0;
                    rf_q[rd_q]  <= alu_result;
                    flags_reg_q <= alu_status;
                end
            end
        end
    end

    assign cmd_ready = (state_q == S_IDLE);
    assign rsp_valid = (state_q == S_RESP);
    assign alu_a     = alu_a_q;
    assign alu_b     = alu_b_q;
    assign alu_f     = alu_f_q;
    assign alu_cin   = flags_reg_q[5];
    assign rsp_data  = rsp_data_q;
    assign rsp_flags = rsp_flags_q;
    assign rsp_err   = rsp_err_q;
    assign flags_q   = flags_reg_q;
    assign dbg_data  = rf_q[dbg_addr];

endmodule
`default_nettype wire

// File: tb/tb_alu_exec_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_exec_ctrl
// Function : Directed bench for alu_exec_ctrl with a small behavioural ALU.
// Revision : 1.0
// ============================================================================
module tb_alu_exec_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cmd_valid, cmd_ready;
    logic [4:0]  cmd_op;
    logic [2:0]  cmd_rd, cmd_rs1, cmd_rs2;
    logic        cmd_imm_en;
    logic [15:0] cmd_imm;
    logic [15:0] alu_a, alu_b;
    logic [4:0]  alu_f;
    logic        alu_cin;
    logic [15:0] alu_result;
    logic [5:0]  alu_status;
    logic        rsp_valid, rsp_ready;
    logic [15:0] rsp_data;
    logic [5:0]  rsp_flags;
    logic        rsp_err;
    logic [5:0]  flags_q;
    logic [2:0]  dbg_addr;
    logic [15:0] dbg_data;

    int tests = 0;
    int fails = 0;

    logic [15:0] r_data;
    logic [5:0]  r_flags;
    logic        r_err;
    logic        exec_cin;

    always #5 clk = ~clk;

    alu_exec_ctrl dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_rd(cmd_rd), .cmd_rs1(cmd_rs1), .cmd_rs2(cmd_rs2),
        .cmd_imm_en(cmd_imm_en), .cmd_imm(cmd_imm),
        .alu_a(alu_a), .alu_b(alu_b), .alu_f(alu_f), .alu_cin(alu_cin),
        .alu_result(alu_result), .alu_status(alu_status),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .rsp_flags(rsp_flags), .rsp_err(rsp_err), .flags_q(flags_q),
        .dbg_addr(dbg_addr), .dbg_data(dbg_data)
    );

    // Behavioural ALU subset: ADD, ADC, RCL, RCR; anything else yields junk
    logic [16:0] m_sum;
    logic [15:0] m_x;
    always_comb begin
        m_sum      = '0;
        m_x        = '0;
        alu_result = alu_a ^ alu_b;
        alu_status = 6'h3F;
        case (alu_f)
            5'h04, 5'h05: begin
                m_sum      = {1'b0, alu_a} + {1'b0, alu_b} + {16'h0, (alu_f == 5'h05) & alu_cin};
                alu_result = m_sum[15:0];
                m_x        = alu_a ^ alu_b ^ m_sum[15:0];
                alu_status = {m_sum[16], m_sum[15:0] == 16'h0, m_sum[15],
                              (alu_a[15] == alu_b[15]) && (m_sum[15] != alu_a[15]),
                              ^m_sum[7:0], m_x[4]};
            end
            5'h16: begin
                alu_result = {alu_a[14:0], alu_cin};
                alu_status = {alu_a[15], alu_result == 16'h0, alu_result[15], 1'b0, ^alu_result[7:0], 1'b0};
            end
            5'h17: begin
                alu_result = {alu_cin, alu_a[15:1]};
                alu_status = {alu_a[0], alu_result == 16'h0, alu_result[15], 1'b0, ^alu_result[7:0], 1'b0};
            end
            default: ;
        endcase
    end

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic peek(input logic [2:0] a, output logic [15:0] d);
        dbg_addr = a;
        #1;
        d = dbg_data;
    endtask

    // Issue one command, record cin during EXEC and the response, then drain it
    task automatic send(input logic [4:0] op, input logic [2:0] rd, input logic [2:0] rs1,
                        input logic [2:0] rs2, input logic ie, input logic [15:0] imm);
        int n;
        cmd_op = op; cmd_rd = rd; cmd_rs1 = rs1; cmd_rs2 = rs2;
        cmd_imm_en = ie; cmd_imm = imm; cmd_valid = 1'b1;
        n = 0;
        while (!cmd_ready && n < 20) begin
            @(posedge clk); #1; n++;
        end
        chk("cmd_ready_wait", 16'(cmd_ready), 16'h1);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        exec_cin  = alu_cin;
        @(posedge clk); #1;
        chk("rsp_latency", 16'(rsp_valid), 16'h1);
        r_data = rsp_data; r_flags = rsp_flags; r_err = rsp_err;
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
    endtask

    initial begin
        logic [15:0] d;
        rst_n = 1'b0; cmd_valid = 1'b0; cmd_op = '0; cmd_rd = '0; cmd_rs1 = '0;
        cmd_rs2 = '0; cmd_imm_en = 1'b0; cmd_imm = '0; rsp_ready = 1'b0; dbg_addr = '0;
        exec_cin = 1'b0; r_data = '0; r_flags = '0; r_err = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_cmd_ready", 16'(cmd_ready), 16'h1);
        chk("rst_rsp_valid", 16'(rsp_valid), 16'h0);
        chk("rst_rsp_data", rsp_data, 16'h0);
        chk("rst_flags", 16'({rsp_flags, flags_q, rsp_err}), 16'h0);
        chk("rst_alu_ops", alu_a | alu_b | 16'(alu_f) | 16'(alu_cin), 16'h0);
        for (int i = 0; i < 8; i++) begin
            peek(3'(i), d);
            chk("rst_regfile", d, 16'h0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Preload and 0x7FFF + 0x0001 signed overflow
        send(5'h04, 3'd1, 3'd0, 3'd0, 1'b1, 16'h7FFF);
        send(5'h04, 3'd2, 3'd0, 3'd0, 1'b1, 16'h0001);
        send(5'h04, 3'd4, 3'd1, 3'd2, 1'b0, 16'h0);
        chk("add_ovf_data", r_data, 16'h8000);
        chk("add_ovf_flags", 16'(r_flags), 16'h000D);
        chk("add_ovf_err", 16'(r_err), 16'h0);
        peek(3'd4, d);
        chk("add_ovf_rd", d, 16'h8000);
        chk("add_ovf_flags_q", 16'(flags_q), 16'h000D);

        // Carry chain
        send(5'h04, 3'd6, 3'd0, 3'd0, 1'b1, 16'hFFFF);
        send(5'h04, 3'd7, 3'd6, 3'd2, 1'b0, 16'h0);
        chk("add_carry_data", r_data, 16'h0000);
        chk("add_carry_flags", 16'(r_flags), 16'h0031);
        send(5'h05, 3'd7, 3'd0, 3'd0, 1'b1, 16'h0000);
        chk("adc_cin", 16'(exec_cin), 16'h1);
        chk("adc_data", r_data, 16'h0001);
        chk("adc_flags", 16'(r_flags), 16'h0002);
        chk("adc_cf_clear", 16'(flags_q[5]), 16'h0);

        // Rotates through carry
        send(5'h04, 3'd7, 3'd6, 3'd2, 1'b0, 16'h0);
        send(5'h16, 3'd7, 3'd4, 3'd0, 1'b0, 16'h0);
        chk("rcl_cin", 16'(exec_cin), 16'h1);
        chk("rcl_data", r_data, 16'h0001);
        chk("rcl_flags", 16'(r_flags), 16'h0022);
        send(5'h17, 3'd7, 3'd7, 3'd0, 1'b0, 16'h0);
        chk("rcr_data", r_data, 16'h8000);
        chk("rcr_flags", 16'(r_flags), 16'h0028);

        // Illegal opcode leaves register file and flags untouched
        send(5'h04, 3'd3, 3'd0, 3'd0, 1'b1, 16'h1234);
        chk("pre_illegal_flags_q", 16'(flags_q), 16'h0002);
        send(5'h1F, 3'd3, 3'd0, 3'd0, 1'b1, 16'hBEEF);
        chk("illegal_err", 16'(r_err), 16'h1);
        chk("illegal_data", r_data, 16'h0000);
        chk("illegal_rsp_flags", 16'(r_flags), 16'h0002);
        peek(3'd3, d);
        chk("illegal_rd_kept", d, 16'h1234);
        chk("illegal_flags_q", 16'(flags_q), 16'h0002);
        send(5'h02, 3'd3, 3'd0, 3'd0, 1'b1, 16'h4321);
        chk("illegal02_err", 16'(r_err), 16'h1);

        // Back-pressure with a second command waiting
        cmd_op = 5'h04; cmd_rd = 3'd5; cmd_rs1 = 3'd0; cmd_imm_en = 1'b1;
        cmd_imm = 16'h0042; cmd_valid = 1'b1;
        @(posedge clk); #1;
        cmd_rd = 3'd1; cmd_imm = 16'h0777;
        chk("bp_exec_busy", 16'(cmd_ready), 16'h0);
        @(posedge clk); #1;
        chk("bp_rsp_valid", 16'(rsp_valid), 16'h1);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            chk("bp_cmd_ready", 16'(cmd_ready), 16'h0);
            chk("bp_rsp_data", rsp_data, 16'h0042);
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        chk("bp_rsp_done", 16'(rsp_valid), 16'h0);
        chk("bp_ready_again", 16'(cmd_ready), 16'h1);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        chk("bp_next_accept", 16'(cmd_ready), 16'h0);
        @(posedge clk); #1;
        chk("bp_next_rsp", rsp_data, 16'h0777);
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        peek(3'd5, d);
        chk("bp_r5", d, 16'h0042);

        // Reset during EXEC of a write to r5
        cmd_op = 5'h04; cmd_rd = 3'd5; cmd_rs1 = 3'd0; cmd_imm_en = 1'b1;
        cmd_imm = 16'h5555; cmd_valid = 1'b1;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        rst_n = 1'b0;
        peek(3'd5, d);
        chk("rst_exec_r5", d, 16'h0000);
        chk("rst_exec_flags_q", 16'(flags_q), 16'h0000);
        chk("rst_exec_rsp_valid", 16'(rsp_valid), 16'h0);
        chk("rst_exec_cmd_ready", 16'(cmd_ready), 16'h1);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        peek(3'd5, d);
        chk("rst_no_late_write", d, 16'h0000);
        chk("rst_idle_rsp_valid", 16'(rsp_valid), 16'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/alu_exec_ctrl.md
# alu_exec_ctrl

Sequencing front-end for the 16-bit combinational ALU. It accepts one command at a time over a valid/ready handshake and reads operands from an 8×16 register file. It drives the ALU operand, opcode and carry-in lines, then captures the ALU result and six status flags into the register file and a flags register. It returns a response over a second valid/ready handshake. It sits directly upstream of the ALU and is the only driver of its inputs.

## Interface
- No parameters: data width 16, 8 registers, 5-bit opcode, all fixed.
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  controller can accept a command
- cmd_op  in  5  ALU opcode
- cmd_rd  in  3  destination register
- cmd_rs1  in  3  source register for the A operand
- cmd_rs2  in  3  source register for the B operand
- cmd_imm_en  in  1  when 1, B is taken from cmd_imm instead of rs2
- cmd_imm  in  16  immediate B operand
- alu_a, alu_b  out  16  ALU operands (registered)
- alu_f  out  5  ALU opcode (registered)
- alu_cin  out  1  ALU carry-in; equals the stored CF flag
- alu_result  in  16  ALU result
- alu_status  in  6  ALU flags {CF,ZF,NF,VF,PF,AF}
- rsp_valid  out  1  response present
- rsp_ready  in  1  consumer accepts the response
- rsp_data  out  16  captured result
- rsp_flags  out  6  captured flags
- rsp_err  out  1  illegal opcode
- flags_q  out  6  architectural flags register
- dbg_addr  in  3  debug register-read address
- dbg_data  out  16  combinational read of regfile[dbg_addr]

## Operation
- States: IDLE, EXEC, RESP. Encoding is free.
- cmd_ready = (state==IDLE). Accept = cmd_valid & cmd_ready.
- IDLE: on accept, latch the following and go to EXEC:
  - alu_a ← reg[rs1]
  - alu_b ← cmd_imm_en ? cmd_imm : reg[rs2]
  - alu_f ← cmd_op
  - an illegal flag ← opcode not legal
- Legal opcodes: 0x01, 0x03–0x0B, 0x10–0x17. All others are illegal, including 0x00, 0x02, 0x0C–0x0F and 0x18–0x1F.
- EXEC, one cycle:
  - ALU output settles combinationally.
  - At the closing edge, rsp_data ← alu_result and rsp_flags ← alu_status.
  - If legal: reg[rd] ← alu_result and flags_q ← alu_status. rsp_err ← 0.
  - If illegal: rsp_data ← 0, rsp_flags ← flags_q, rsp_err ← 1; no register or flags write.
  - Go to RESP.
- RESP: rsp_valid=1, and rsp_data, rsp_flags and rsp_err are held stable. When rsp_ready=1, go to IDLE.
- alu_cin = flags_q[5] at all times. It is the same value during EXEC because flags_q only updates on the EXEC-closing edge.
- Register reads in IDLE see every prior writeback, so there are no hazards. rs1==rs2==rd is legal.
- No register is hardwired to zero.
- alu_a, alu_b and alu_f hold their last values outside EXEC.

## Timing
- Reset (async assert, release sync to clk) sets:
  - state=IDLE, so cmd_ready=1
  - rsp_valid=0, rsp_err=0
  - rsp_data=0, rsp_flags=0, flags_q=0
  - alu_a=0, alu_b=0, alu_f=0, hence alu_cin=0
  - all 8 registers = 0
- Latency: command accepted at edge N; EXEC during cycle N→N+1; rsp_valid=1 from edge N+1.
- Response accepted at edge M (rsp_valid & rsp_ready): rsp_valid=0 and cmd_ready=1 from edge M. The next command can be accepted at edge M+1.
- Peak throughput is 1 command per 3 cycles, with rsp_ready tied high.
- cmd_valid while not ready is ignored. The command must be held by the source per valid/ready rules.
- rsp_ready while rsp_valid=0 is ignored.
- Stalled response (rsp_ready=0 for k cycles): state stays RESP and outputs are stable. No new command is accepted.
- Reset asserted mid-EXEC or mid-RESP: immediate return to reset values. The in-flight command is lost and its writeback does not occur.
- dbg_data is a pure combinational read. It reflects a write from the edge that performs it.

## Test plan
- Reset, then {op=0x04 ADD, rs1=r1 (0x7FFF), rs2=r2 (0x0001)}. Registers are preloaded by immediate ADD into zeroed r0 sources (e.g. r0+0x7FFF). → rsp at N+1: rsp_data=0x8000, rsp_flags={0,0,1,1,0,1}; rd holds 0x8000; flags_q matches rsp_flags.
- Carry chain:
  - ADD 0xFFFF+0x0001 → CF=1, ZF=1, result 0.
  - Then ADC (0x05) with 0x0000+0x0000 → alu_cin=1 during EXEC, result 0x0001, CF=0.
- RCL (0x16) on 0x8000 with flags_q CF=1 → result 0x0001, CF=1. Subsequent RCR (0x17) on 0x0001 → 0x8000, CF=1.
- Illegal opcode 0x1F with rd=r3 holding 0x1234 → rsp_err=1, rsp_data=0, rsp_flags equals prior flags_q; r3 still 0x1234 via dbg_data; flags_q unchanged.
- Back-pressure: rsp_ready=0 for 5 cycles while cmd_valid=1 → cmd_ready=0 throughout and rsp_data stable. Raise rsp_ready → next command accepted exactly 1 cycle after the response is accepted.
- Assert rst_n=0 during EXEC of a write to r5 → r5=0, flags_q=0, rsp_valid=0, cmd_ready=1 immediately; no late write after release.
